// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receiver: frame FSM states, prefix bytes,
// default timing parameters and the frame validity rule.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PREFIX_UP  = 8'hF0;

  localparam int DEFAULT_FILTER_LEN = 8;
  localparam int DEFAULT_TIMEOUT    = 50000;

  // A frame is good when the stop bit is high and data plus parity carry an
  // odd number of ones.
  function automatic logic frame_ok(input logic [7:0] data, input logic parity,
                                    input logic stop);
    return stop & (^{data, parity});
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// One PS/2 line: two-flop synchronizer followed by a persistence filter.
// The filtered level only follows the synchronized input after it has
// differed for FILTER_LEN consecutive cycles, so shorter glitches vanish.
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = DEFAULT_FILTER_LEN
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]    sync_reg;
  logic [CW-1:0] cnt_reg;
  logic          level_reg;

  // Synchronize the raw line, then count cycles of disagreement with the
  // filtered level; flip the level once the count has reached FILTER_LEN-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg  <= 2'b11;
      cnt_reg   <= '0;
      level_reg <= 1'b1;
    end else begin
      sync_reg <= {sync_reg[0], raw};
      if (sync_reg[1] != level_reg) begin
        if (cnt_reg == CW'(FILTER_LEN - 1)) begin
          level_reg <= sync_reg[1];
          cnt_reg   <= '0;
        end else begin
          cnt_reg <= cnt_reg + CW'(1);
        end
      end else begin
        cnt_reg <= '0;
      end
    end
  end

  assign level = level_reg;

endmodule

// File: rtl/ps2_rx_sync.sv
// PS/2 keyboard receiver: filters both bus lines, frames 11-bit PS/2
// characters on falling clock edges, folds E0/F0 prefixes into flags and
// reports each complete scan code with a one-cycle event strobe.
module ps2_rx_sync
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = DEFAULT_FILTER_LEN,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] ps2_bus,
  output logic [7:0] ps2_code,
  output logic       ps2_up,
  output logic       ps2_ext,
  output logic       ps2_event,
  output logic       ps2_err
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  // filt[1] is the filtered clock, filt[0] the filtered data
  logic [1:0] filt;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_line
      ps2_line_filter #(
        .FILTER_LEN(FILTER_LEN)
      ) u_filter (
        .clk  (clk),
        .rst  (rst),
        .raw  (ps2_bus[gi]),
        .level(filt[gi])
      );
    end
  endgenerate

  logic clk_prev_reg;
  logic fall;
  logic data_bit;

  // Remember the previous filtered clock level for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_prev_reg <= 1'b1;
    end else begin
      clk_prev_reg <= filt[1];
    end
  end

  assign fall     = clk_prev_reg & ~filt[1];
  assign data_bit = filt[0];

  ps2_state_t    state_reg;
  logic [7:0]    shift_reg;
  logic [2:0]    bit_cnt_reg;
  logic          parity_reg;
  logic [TW-1:0] timer_reg;
  logic          pend_up_reg;
  logic          pend_ext_reg;
  logic [7:0]    code_reg;
  logic          up_reg;
  logic          ext_reg;
  logic          event_reg;
  logic          err_reg;

  // Frame FSM, inter-edge timeout and prefix/output bookkeeping. A fall
  // always wins over a timeout expiring in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      bit_cnt_reg  <= '0;
      parity_reg   <= 1'b0;
      timer_reg    <= '0;
      pend_up_reg  <= 1'b0;
      pend_ext_reg <= 1'b0;
      code_reg     <= '0;
      up_reg       <= 1'b0;
      ext_reg      <= 1'b0;
      event_reg    <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      event_reg <= 1'b0;
      err_reg   <= 1'b0;
      if (fall) begin
        timer_reg <= '0;
        case (state_reg)
          IDLE: begin
            // a high data line on a fall is not a start bit; ignore it
            if (!data_bit) begin
              state_reg   <= DATA;
              bit_cnt_reg <= '0;
            end
          end
          DATA: begin
            shift_reg <= {data_bit, shift_reg[7:1]};
            if (bit_cnt_reg == 3'd7) begin
              state_reg <= PARITY;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
            end
          end
          PARITY: begin
            parity_reg <= data_bit;
            state_reg  <= STOP;
          end
          STOP: begin
            state_reg <= IDLE;
            if (frame_ok(shift_reg, parity_reg, data_bit)) begin
              if (shift_reg == PREFIX_EXT) begin
                pend_ext_reg <= 1'b1;
              end else if (shift_reg == PREFIX_UP) begin
                pend_up_reg <= 1'b1;
              end else begin
                code_reg     <= shift_reg;
                up_reg       <= pend_up_reg;
                ext_reg      <= pend_ext_reg;
                event_reg    <= 1'b1;
                pend_up_reg  <= 1'b0;
                pend_ext_reg <= 1'b0;
              end
            end else begin
              err_reg      <= 1'b1;
              pend_up_reg  <= 1'b0;
              pend_ext_reg <= 1'b0;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end else if (state_reg != IDLE) begin
        if (timer_reg == TW'(TIMEOUT - 1)) begin
          err_reg      <= 1'b1;
          pend_up_reg  <= 1'b0;
          pend_ext_reg <= 1'b0;
          shift_reg    <= '0;
          bit_cnt_reg  <= '0;
          timer_reg    <= '0;
          state_reg    <= IDLE;
        end else begin
          timer_reg <= timer_reg + TW'(1);
        end
      end
    end
  end

  assign ps2_code  = code_reg;
  assign ps2_up    = up_reg;
  assign ps2_ext   = ext_reg;
  assign ps2_event = event_reg;
  assign ps2_err   = err_reg;

endmodule

// File: tb/tb_ps2_rx_sync.sv
// Scoreboard bench for ps2_rx_sync: frames are bit-banged onto the bus, a
// reference model predicts each event/error and a monitor checks them.
module tb_ps2_rx_sync;

  localparam int FLEN = 8;
  localparam int TOUT = 1000;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       line_clk = 1'b1;
  logic       line_data = 1'b1;
  logic [1:0] bus;
  logic [7:0] ps2_code;
  logic       ps2_up, ps2_ext, ps2_event, ps2_err;

  assign bus = {line_clk, line_data};

  ps2_rx_sync #(.FILTER_LEN(FLEN), .TIMEOUT(TOUT)) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_bus  (bus),
    .ps2_code (ps2_code),
    .ps2_up   (ps2_up),
    .ps2_ext  (ps2_ext),
    .ps2_event(ps2_event),
    .ps2_err  (ps2_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       is_err;
    bit [7:0] code;
    bit       up;
    bit       ext;
  } exp_t;

  exp_t exp_q[$];
  int   compared = 0;
  int   mismatched = 0;

  // reference model state
  bit [7:0] m_code = 8'h00;
  bit       m_up = 1'b0, m_ext = 1'b0, m_pend_up = 1'b0, m_pend_ext = 1'b0;

  task automatic check(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input bit b);
    line_data = b;
    wait_cyc(HALF);
    line_clk = 1'b0;
    wait_cyc(HALF);
    line_clk = 1'b1;
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1; e.code = m_code; e.up = m_up; e.ext = m_ext;
    exp_q.push_back(e);
    m_pend_up = 1'b0;
    m_pend_ext = 1'b0;
  endtask

  // Predict the outcome of a whole frame from the bits actually sent.
  task automatic model_frame(input bit [7:0] d, input bit par, input bit stop);
    exp_t e;
    bit valid;
    valid = stop && ($countones({d, par}) % 2 == 1);
    if (!valid) begin
      push_err();
    end else if (d == 8'hE0) begin
      m_pend_ext = 1'b1;
    end else if (d == 8'hF0) begin
      m_pend_up = 1'b1;
    end else begin
      m_code = d; m_up = m_pend_up; m_ext = m_pend_ext;
      m_pend_up = 1'b0; m_pend_ext = 1'b0;
      e.is_err = 1'b0; e.code = m_code; e.up = m_up; e.ext = m_ext;
      exp_q.push_back(e);
    end
  endtask

  task automatic send_frame(input bit [7:0] d, input bit flip_par, input bit stop);
    bit par;
    par = ($countones(d) % 2 == 0) ^ flip_par;
    model_frame(d, par, stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stop);
    line_data = 1'b1;
    wait_cyc(2 * HALF);
  endtask

  task automatic glitch_clk(input int len);
    line_data = 1'b0;
    wait_cyc(30);
    line_clk = 1'b0;
    wait_cyc(len);
    line_clk = 1'b1;
    wait_cyc(30);
    line_data = 1'b1;
    wait_cyc(30);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_code"}, ps2_code, 0);
    check({tag, "_up"}, ps2_up, 0);
    check({tag, "_ext"}, ps2_ext, 0);
    check({tag, "_event"}, ps2_event, 0);
    check({tag, "_err"}, ps2_err, 0);
  endtask

  // Monitor: every strobe pops one prediction and is compared field by field.
  always @(negedge clk) begin
    if (!rst) begin
      if (ps2_event && ps2_err) begin
        compared++;
        mismatched++;
        $display("FAIL strobe_overlap: event and err both high");
      end else if (ps2_event || ps2_err) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_strobe: got event=%0b err=%0b code=%0h, expected none",
                   ps2_event, ps2_err, ps2_code);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (ps2_err != e.is_err || ps2_code != e.code || ps2_up != e.up || ps2_ext != e.ext) begin
            mismatched++;
            $display("FAIL strobe: got err=%0b code=%0h up=%0b ext=%0b, expected err=%0b code=%0h up=%0b ext=%0b",
                     ps2_err, ps2_code, ps2_up, ps2_ext, e.is_err, e.code, e.up, e.ext);
          end else begin
            $display("%s code=%0h up=%0b ext=%0b ok", e.is_err ? "err  " : "event",
                     ps2_code, ps2_up, ps2_ext);
          end
        end
      end
    end
  end

  // Global bound so the run always ends.
  initial begin
    #(20_000_000);
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    wait_cyc(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    wait_cyc(20);

    // clean frames and prefix combinations
    send_frame(8'h1C, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'h70, 1'b0, 1'b1);
    send_frame(8'hE1, 1'b0, 1'b1);

    // bad parity, then bad stop with a pending prefix that must be dropped
    send_frame(8'h1C, 1'b1, 1'b1);
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'h2A, 1'b0, 1'b0);
    send_frame(8'h2A, 1'b0, 1'b1);
    check("hold_code", ps2_code, m_code);

    // a fall with data high in IDLE is not a start bit
    send_bit(1'b1);
    wait_cyc(2 * HALF);
    send_frame(8'h33, 1'b0, 1'b1);

    // glitches on the clock line shorter than the filter length
    glitch_clk(3);
    glitch_clk(3);
    glitch_clk(FLEN - 1);
    send_frame(8'h1C, 1'b0, 1'b1);

    // timeout in the middle of a frame after an E0 prefix
    send_frame(8'hE0, 1'b0, 1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    push_err();
    wait_cyc(TOUT - 100);
    check("timeout_not_early", exp_q.size(), 1);
    wait_cyc(200);
    check("timeout_fired", exp_q.size(), 0);
    send_frame(8'h1C, 1'b0, 1'b1);

    // reset after the 5th data bit, with an E0 pending
    send_frame(8'hE0, 1'b0, 1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    line_data = 1'b1;
    rst = 1'b1;
    wait_cyc(4);
    check_reset_outputs("midreset");
    rst = 1'b0;
    m_code = 8'h00; m_up = 1'b0; m_ext = 1'b0; m_pend_up = 1'b0; m_pend_ext = 1'b0;
    wait_cyc(2 * HALF);
    send_frame(8'h1C, 1'b0, 1'b1);

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      int r;
      bit [7:0] d;
      r = $urandom_range(0, 15);
      if (r < 3) d = 8'hE0;
      else if (r < 6) d = 8'hF0;
      else d = 8'($urandom);
      send_frame(d, $urandom_range(0, 9) == 0, $urandom_range(0, 14) != 0);
    end

    wait_cyc(100);
    check("queue_drained", exp_q.size(), 0);
    check("final_code", ps2_code, m_code);
    check("final_up", ps2_up, m_up);
    check("final_ext", ps2_ext, m_ext);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ps2_rx_sync.md
PS2_RX_SYNC -- requirements
Module: ps2_rx_sync

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8: consecutive clk cycles a PS/2 line must hold a new level before the filtered level changes.
REQ-002 SHALL have parameter TIMEOUT, default 50000: clk cycles allowed between falling PS/2 clock edges inside a frame.
REQ-003 clk  input  1  system clock; the block has one clock, and all logic SHALL run on its rising edge.
REQ-004 rst  input  1  reset; SHALL be synchronous and active-high.
REQ-005 ps2_bus  input  2  raw asynchronous lines {ps2_clk, ps2_data}, bit 1 = clock.
REQ-006 ps2_code  output  8  last non-prefix scan code received.
REQ-007 ps2_up  output  1  set when an F0 prefix preceded ps2_code.
REQ-008 ps2_ext  output  1  set when an E0 prefix preceded ps2_code.
REQ-009 ps2_event  output  1  one-cycle strobe that marks new ps2_code/ps2_up/ps2_ext values.
REQ-010 ps2_err  output  1  one-cycle strobe on a framing, parity or timeout error.

Function
REQ-011 Each ps2_bus line SHALL pass through a 2-flop synchronizer, then a filter.
REQ-012 The filter counter SHALL count cycles where the synchronized input differs from the filtered level, and clear to 0 when they are equal.
REQ-013 The filtered level SHALL flip on the cycle the counter reaches FILTER_LEN-1; glitches shorter than FILTER_LEN cycles SHALL be ignored.
REQ-014 A falling edge of the filtered clock (fall) SHALL be a one-cycle internal strobe; the filtered data is sampled on that cycle.
REQ-015 The frame FSM SHALL have states IDLE, DATA, PARITY and STOP.
REQ-016 In IDLE: fall with data=0 -> DATA with bit counter 0; fall with data=1 -> stay in IDLE, no error.
REQ-017 In DATA, each fall SHALL shift data in LSB first; after the 8th bit (counter 7) the FSM SHALL go to PARITY.
REQ-018 In PARITY, fall SHALL store the parity bit and go to STOP.
REQ-019 In STOP, fall SHALL go to IDLE; the frame is valid when stop=1 and the 8 data bits plus parity have odd parity.
REQ-020 Valid byte E0 SHALL set the pending-ext flag, with no event.
REQ-021 Valid byte F0 SHALL set the pending-up flag, with no event.
REQ-022 Any other valid byte, including E1, SHALL update ps2_code, ps2_up and ps2_ext from the byte and pending flags.
REQ-023 On that same update edge ps2_event SHALL pulse high for exactly one cycle and both pending flags SHALL clear.
REQ-024 Latency: ps2_event SHALL be asserted in the cycle after the stop-bit fall cycle.
REQ-025 An invalid frame (bad parity or stop=0) SHALL pulse ps2_err for one cycle, clear the pending flags, leave the outputs unchanged and return to IDLE.
REQ-026 The timeout timer SHALL reset on every fall and count only when the FSM is not in IDLE.
REQ-027 When the timer reaches TIMEOUT-1, the block SHALL pulse ps2_err, clear the pending flags and the shift register, and force IDLE.
REQ-028 A fall in the same cycle as a timeout SHALL take priority: the timer reloads and no error is raised.
REQ-029 ps2_code, ps2_up and ps2_ext SHALL hold between events; ps2_event and ps2_err SHALL never be high in the same cycle.
REQ-030 Prefixes SHALL accumulate in any order: E0, F0, 70 -> ps2_ext=1, ps2_up=1, ps2_code=70.

Reset
REQ-031 While rst=1: FSM=IDLE; shift register, bit counter, timer and pending flags = 0; filtered levels = 1; filter counters = 0.
REQ-032 While rst=1: ps2_code=0, ps2_up=0, ps2_ext=0, ps2_event=0, ps2_err=0.
REQ-033 Reset mid-frame SHALL discard the partial byte with no error pulse.

Structure
REQ-034 Package ps2_pkg SHALL hold the FSM state typedef, the prefix constants (8'hE0, 8'hF0) and the default FILTER_LEN and TIMEOUT.
REQ-035 Sub-module ps2_line_filter (synchronizer + filter, parameter FILTER_LEN) SHALL be instantiated twice, once per line.

Verification
REQ-036 Frame 1C with odd parity correct (clean) -> one ps2_event, ps2_code=1C, ps2_up=0, ps2_ext=0.
REQ-037 Frames F0, 1C -> exactly one ps2_event, with ps2_code=1C and ps2_up=1.
REQ-038 Frames E0, F0, 75 -> exactly one ps2_event, with ps2_code=75, ps2_up=1, ps2_ext=1.
REQ-039 Frame 1C with the parity bit flipped -> one ps2_err pulse, no event, outputs unchanged.
REQ-040 Frame E0, then 4 data bits, then clock held high for TIMEOUT cycles -> one ps2_err, FSM IDLE, pending flags clear; the next 1C frame -> event with ps2_ext=0.
REQ-041 Glitches of 3-cycle low pulses on ps2_clk in IDLE, FILTER_LEN=8 -> no state change; rst asserted after the 5th data bit -> all outputs 0 and a following frame decodes correctly.
